// File: rtl/lane_done_sync.sv
// rtl/lane_done_sync.sv - per-channel aggregation of in-order lane done pulses into one done per instruction
// Optional error flags under `LANE_DONE_SYNC_ERR_EN; lane l / channel c uses bit l*NrChan+c of the flat inputs.
module lane_done_sync #(
    parameter int NrLane = 4,
    parameter int NrChan = 4,
    parameter int IdW    = 3,
    parameter int Depth  = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrLane-1:0]               lane_mask_i,
    input  logic                            flush_i,
    input  logic [NrLane*NrChan-1:0]        lane_done_i,
    input  logic [NrLane*NrChan*IdW-1:0]    lane_id_i,
    output logic [NrChan-1:0]               done_o,
    output logic [NrChan*IdW-1:0]           done_id_o,
    output logic [NrChan-1:0]               ovf_err_o,
    output logic [NrChan-1:0]               id_err_o
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    logic [NrChan-1:0][Depth-1:0]              valid_q, valid_d;
    logic [NrChan-1:0][Depth-1:0][IdW-1:0]     id_q, id_d;
    logic [NrChan-1:0][Depth-1:0][NrLane-1:0]  mask_q, mask_d;
    logic [NrChan-1:0][PW-1:0]                 head_q, head_d;
    logic [NrChan-1:0][NrLane-1:0][PW-1:0]     wr_q, wr_d;
    logic [NrChan-1:0]                         retire;

`ifdef LANE_DONE_SYNC_ERR_EN
    logic [NrChan-1:0] ovf_err_q, ovf_err_d, ovf_set;
    logic [NrChan-1:0] id_err_q, id_err_d, id_mis;
`endif

    always_comb begin
        logic [AW-1:0]  hidx;
        logic [AW-1:0]  widx;
        logic [IdW-1:0] lid;
        int             k;
        valid_d = valid_q;
        id_d    = id_q;
        mask_d  = mask_q;
        head_d  = head_q;
        wr_d    = wr_q;
        retire  = '0;
        hidx    = '0;
        widx    = '0;
        lid     = '0;
        k       = 0;
`ifdef LANE_DONE_SYNC_ERR_EN
        ovf_set = '0;
        id_mis  = '0;
`endif
        for (int c = 0; c < NrChan; c++) begin
            hidx      = head_q[c][AW-1:0];
            retire[c] = valid_q[c][hidx] && (mask_q[c][hidx] == lane_mask_i);
            // Retire is applied first so an arrival into the freed slot lands on a clean entry
            if (retire[c]) begin
                valid_d[c][hidx] = 1'b0;
                id_d[c][hidx]    = '0;
                mask_d[c][hidx]  = '0;
                head_d[c]        = head_q[c] + PW'(1);
            end
            for (int l = 0; l < NrLane; l++) begin
                k   = l * NrChan + c;
                lid = lane_id_i[k*IdW +: IdW];
                if (!lane_mask_i[l]) begin
                    // Inactive lanes shadow the head so re-enabling them lines up with the next entry
                    wr_d[c][l] = head_d[c];
                end else if (lane_done_i[k]) begin
                    if ((wr_q[c][l] - head_q[c]) == PW'(Depth) && !retire[c]) begin
`ifdef LANE_DONE_SYNC_ERR_EN
                        ovf_set[c] = 1'b1;
`endif
                    end else begin
                        widx = wr_q[c][l][AW-1:0];
                        mask_d[c][widx][l] = 1'b1;
                        if (!valid_d[c][widx]) begin
                            valid_d[c][widx] = 1'b1;
                            id_d[c][widx]    = lid;
`ifdef LANE_DONE_SYNC_ERR_EN
                        end else if (id_d[c][widx] != lid) begin
                            id_mis[c] = 1'b1;
`endif
                        end
                        wr_d[c][l] = wr_q[c][l] + PW'(1);
                    end
                end
            end
        end
        if (flush_i) begin
            valid_d = '0;
            id_d    = '0;
            mask_d  = '0;
            head_d  = '0;
            wr_d    = '0;
`ifdef LANE_DONE_SYNC_ERR_EN
            ovf_set = '0;
            id_mis  = '0;
`endif
        end
`ifdef LANE_DONE_SYNC_ERR_EN
        ovf_err_d = ovf_err_q | ovf_set;
        id_err_d  = id_err_q | id_mis;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            id_q    <= '0;
            mask_q  <= '0;
            head_q  <= '0;
            wr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            mask_q  <= mask_d;
            head_q  <= head_d;
            wr_q    <= wr_d;
        end
    end

`ifdef LANE_DONE_SYNC_ERR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_err_q <= '0;
            id_err_q  <= '0;
        end else begin
            ovf_err_q <= ovf_err_d;
            id_err_q  <= id_err_d;
        end
    end
    assign ovf_err_o = ovf_err_q;
    assign id_err_o  = id_err_q;
`else
    assign ovf_err_o = '0;
    assign id_err_o  = '0;
`endif

    always_comb begin
        done_o    = retire;
        done_id_o = '0;
        for (int c = 0; c < NrChan; c++) begin
            if (retire[c]) begin
                done_id_o[c*IdW +: IdW] = id_q[c][head_q[c][AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_lane_done_sync.sv
// tb/tb_lane_done_sync.sv - self-checking bench for lane_done_sync (default parameters)
// Scoreboard of expected {cycle, channel, id} completions checked every cycle by a monitor.
module tb_lane_done_sync;

    localparam int NL = 4;
    localparam int NC = 4;
    localparam int IW = 3;

`ifdef LANE_DONE_SYNC_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NL-1:0]         lane_mask = '1;
    logic                  flush = 1'b0;
    logic [NL*NC-1:0]      lane_done = '0;
    logic [NL*NC*IW-1:0]   lane_id = '0;
    logic [NC-1:0]         done;
    logic [NC*IW-1:0]      done_id;
    logic [NC-1:0]         ovf_err;
    logic [NC-1:0]         id_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int cyc;
        int ch;
        int id;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int       ch;
        int       id;
        logic [3:0] lanes_a;
        logic [3:0] lanes_b;
    } vec_t;
    vec_t vecs[5];

    lane_done_sync dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .lane_mask_i (lane_mask),
        .flush_i     (flush),
        .lane_done_i (lane_done),
        .lane_id_i   (lane_id),
        .done_o      (done),
        .done_id_o   (done_id),
        .ovf_err_o   (ovf_err),
        .id_err_o    (id_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle the done vector and ids must equal what the scoreboard holds for this cycle
    always @(negedge clk) begin
        logic [NC-1:0]    exp_done;
        logic [NC*IW-1:0] exp_id;
        exp_t e;
        if (mon_en) begin
            exp_done = '0;
            exp_id   = '0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL stale_expect: ch %0d id %0d due cycle %0d never seen", e.ch, e.id, e.cyc);
                end else begin
                    exp_done[e.ch] = 1'b1;
                    exp_id[e.ch*IW +: IW] = IW'(e.id);
                end
            end
            chk("done_o", 32'(done), 32'(exp_done));
            chk("done_id_o", 32'(done_id), 32'(exp_id));
        end
    end

    task automatic add(input int ch, input int lane, input int id);
        lane_done[lane*NC+ch] = 1'b1;
        lane_id[(lane*NC+ch)*IW +: IW] = IW'(id);
    endtask

    task automatic add_lanes(input int ch, input logic [3:0] lanes, input int id);
        for (int l = 0; l < NL; l++) if (lanes[l]) add(ch, l, id);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lane_done = '0;
        lane_id   = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_done(input int ch, input int id);
        exp_t e;
        e.cyc = cyc + 1;
        e.ch  = ch;
        e.id  = id;
        sb.push_back(e);
    endtask

    initial begin
        vecs[0] = '{ch: 0, id: 3, lanes_a: 4'hF, lanes_b: 4'h0};
        vecs[1] = '{ch: 1, id: 5, lanes_a: 4'h3, lanes_b: 4'hC};
        vecs[2] = '{ch: 2, id: 7, lanes_a: 4'h1, lanes_b: 4'hE};
        vecs[3] = '{ch: 3, id: 0, lanes_a: 4'h5, lanes_b: 4'hA};
        vecs[4] = '{ch: 0, id: 6, lanes_a: 4'h8, lanes_b: 4'h7};

        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_done_id", 32'(done_id), 32'h0);
        chk("reset_ovf", 32'(ovf_err), 32'h0);
        chk("reset_iderr", 32'(id_err), 32'h0);
        mon_en = 1'b1;
        idle(2);

        // all lanes finish ch0 together
        add_lanes(0, 4'hF, 3);
        expect_done(0, 3);
        step();
        idle(2);

        // staggered arrivals on ch1
        add(1, 0, 5); step(); idle(1);
        add(1, 1, 5); step(); idle(2);
        add(1, 2, 5); step(); idle(1);
        add(1, 3, 5); expect_done(1, 5); step();
        idle(2);

        for (int i = 0; i < 5; i++) begin
            add_lanes(vecs[i].ch, vecs[i].lanes_a, vecs[i].id);
            if (vecs[i].lanes_b == 4'h0) expect_done(vecs[i].ch, vecs[i].id);
            step();
            if (vecs[i].lanes_b != 4'h0) begin
                add_lanes(vecs[i].ch, vecs[i].lanes_b, vecs[i].id);
                expect_done(vecs[i].ch, vecs[i].id);
                step();
            end
            idle(1);
        end
        idle(2);

        // partial mask: lanes 2,3 ignored
        lane_mask = 4'b0011;
        idle(1);
        add_lanes(0, 4'b0011, 2);
        expect_done(0, 2);
        step();
        add_lanes(0, 4'b1100, 2);
        step();
        idle(3);
        lane_mask = 4'hF;
        idle(1);
        add_lanes(0, 4'hF, 4);
        expect_done(0, 4);
        step();
        idle(2);

        // overflow on ch2: fifth pulse from lane 0 dropped
        for (int k = 0; k < 5; k++) begin
            add(2, 0, k);
            step();
        end
        chk("ovf_err_ch2", 32'(ovf_err), 32'({ERR_ON, 2'b00}));
        for (int k = 0; k < 4; k++) begin
            add_lanes(2, 4'hE, k);
            expect_done(2, k);
            step();
        end
        idle(3);

        // ID mismatch on ch3, first lane's ID wins
        add(3, 0, 1);
        add(3, 1, 6);
        step();
        chk("id_err_ch3", 32'(id_err), 32'({ERR_ON, 3'b000}));
        add_lanes(3, 4'hC, 1);
        expect_done(3, 1);
        step();
        idle(2);

        // flush discards partial entry and the flush-cycle pulses, keeps error flags
        add_lanes(1, 4'h3, 2);
        step();
        flush = 1'b1;
        add_lanes(1, 4'hC, 2);
        step();
        flush = 1'b0;
        idle(3);
        chk("ovf_after_flush", 32'(ovf_err), 32'({ERR_ON, 2'b00}));
        chk("iderr_after_flush", 32'(id_err), 32'({ERR_ON, 3'b000}));
        add_lanes(1, 4'hF, 4);
        expect_done(1, 4);
        step();
        idle(2);

        // reset mid-operation discards the partial completion
        add_lanes(0, 4'h3, 5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ovf_after_rst", 32'(ovf_err), 32'h0);
        chk("iderr_after_rst", 32'(id_err), 32'h0);
        add_lanes(0, 4'hC, 5);
        step();
        idle(3);
        add_lanes(0, 4'h3, 5);
        expect_done(0, 5);
        step();
        idle(1);
        add_lanes(0, 4'hF, 7);
        expect_done(0, 7);
        step();
        idle(4);

        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
